// File: rtl/multicycle_sequencer_pkg.sv
// Shared definitions for the multicycle sequencer: state codes, RV32I opcodes,
// datapath select encodings and the decoded-control bundle.
package multicycle_sequencer_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_FETCH  = 3'd0;
    localparam state_t ST_DECODE = 3'd1;
    localparam state_t ST_EXEC   = 3'd2;
    localparam state_t ST_MEM    = 3'd3;
    localparam state_t ST_WB     = 3'd4;
    localparam state_t ST_HALT   = 3'd5;
    localparam state_t ST_TRAP   = 3'd6;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef enum logic [1:0] {
        PC_SRC_PLUS4  = 2'd0,
        PC_SRC_BRANCH = 2'd1,
        PC_SRC_JAL    = 2'd2,
        PC_SRC_JALR   = 2'd3
    } pc_src_e;

    typedef enum logic [1:0] {
        WB_ALU  = 2'd0,
        WB_MEM  = 2'd1,
        WB_PC4  = 2'd2,
        WB_IMM  = 2'd3
    } wb_sel_e;

    typedef enum logic [1:0] {
        TRAP_NONE        = 2'd0,
        TRAP_ILLEGAL     = 2'd1,
        TRAP_BUS_TIMEOUT = 2'd2
    } trap_cause_e;

    // Everything the FSM needs to know about the held instruction.
    typedef struct packed {
        logic    legal;
        logic    is_system;
        logic    is_load;
        logic    is_store;
        logic    is_branch;
        logic    alu_src_a;
        logic    alu_src_b;
        wb_sel_e wb_sel;
        pc_src_e pc_src;
    } decode_t;

endpackage

// File: rtl/seq_decode.sv
// Combinational opcode decoder: maps IR[6:0] onto the control bundle consumed
// by the multicycle sequencer FSM.
module seq_decode
    import multicycle_sequencer_pkg::*;
(
    input  logic [6:0] opcode,
    output decode_t    dec
);

    always_comb begin
        // NOTE: every field gets a default before the case so no path leaves
        // a field unassigned, which would otherwise infer a latch.
        dec           = '0;
        dec.legal     = 1'b1;
        dec.wb_sel    = WB_ALU;
        dec.pc_src    = PC_SRC_PLUS4;
        case (opcode)
            OPC_LOAD: begin
                dec.is_load   = 1'b1;
                dec.alu_src_b = 1'b1;
                dec.wb_sel    = WB_MEM;
            end
            OPC_STORE: begin
                dec.is_store  = 1'b1;
                dec.alu_src_b = 1'b1;
            end
            OPC_OP: begin
                dec.alu_src_b = 1'b0;
            end
            OPC_OP_IMM: begin
                dec.alu_src_b = 1'b1;
            end
            OPC_BRANCH: begin
                // ALU forms the target (pc + imm); the comparator sees rs1/rs2.
                dec.is_branch = 1'b1;
                dec.alu_src_a = 1'b1;
            end
            OPC_JAL: begin
                dec.alu_src_a = 1'b1;
                dec.alu_src_b = 1'b1;
                dec.wb_sel    = WB_PC4;
                dec.pc_src    = PC_SRC_JAL;
            end
            OPC_JALR: begin
                dec.alu_src_b = 1'b1;
                dec.wb_sel    = WB_PC4;
                dec.pc_src    = PC_SRC_JALR;
            end
            OPC_LUI: begin
                dec.alu_src_b = 1'b1;
                dec.wb_sel    = WB_IMM;
            end
            OPC_AUIPC: begin
                dec.alu_src_a = 1'b1;
                dec.alu_src_b = 1'b1;
            end
            OPC_SYSTEM: begin
                dec.is_system = 1'b1;
            end
            default: begin
                dec.legal = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/multicycle_sequencer.sv
// Multicycle RV32I control sequencer: FETCH/DECODE/EXEC/MEM/WB FSM with bus
// wait timeout, sticky HALT/TRAP, and per-state control strobes.
module multicycle_sequencer
    import multicycle_sequencer_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic       imem_ready,
    input  logic       dmem_ready,
    input  logic       branch_taken,
    output logic       imem_req,
    output logic       ir_load,
    output logic       dmem_req,
    output logic       dmem_we,
    output logic       alu_src_a,
    output logic       alu_src_b,
    output logic       rf_we,
    output logic [1:0] wb_sel,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic       retired,
    output logic [2:0] state,
    output logic       halted,
    output logic [1:0] trap_cause
);

    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(MEM_TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] wait_q, wait_d;
    trap_cause_e      trap_q, trap_d;
    decode_t          dec;
    logic             timeout;

    seq_decode u_decode (
        .opcode (opcode),
        .dec    (dec)
    );

    // Last permitted wait cycle: ready low here means the bus has given up.
    assign timeout = (wait_q == LAST_WAIT);

    always_comb begin
        state_d = state_q;
        wait_d  = '0;
        trap_d  = trap_q;
        case (state_q)
            ST_FETCH: begin
                if (imem_ready) begin
                    state_d = ST_DECODE;
                end else if (timeout) begin
                    state_d = ST_TRAP;
                    trap_d  = TRAP_BUS_TIMEOUT;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            ST_DECODE: begin
                if (dec.is_system) begin
                    state_d = ST_HALT;
                end else if (!dec.legal) begin
                    state_d = ST_TRAP;
                    trap_d  = TRAP_ILLEGAL;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (dec.is_load || dec.is_store) begin
                    state_d = ST_MEM;
                end else if (dec.is_branch) begin
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_MEM: begin
                if (dmem_ready) begin
                    state_d = dec.is_store ? ST_FETCH : ST_WB;
                end else if (timeout) begin
                    state_d = ST_TRAP;
                    trap_d  = TRAP_BUS_TIMEOUT;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            ST_WB:   state_d = ST_FETCH;
            ST_HALT: state_d = ST_HALT;
            ST_TRAP: state_d = ST_TRAP;
            default: state_d = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples its pre-edge value, independent of statement order.
        if (reset) begin
            state_q <= ST_FETCH;
            wait_q  <= '0;
            trap_q  <= TRAP_NONE;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            trap_q  <= trap_d;
        end
    end

    // Strobes are gated by reset so an instruction caught mid-flight never
    // retires or writes back during the reset cycle.
    always_comb begin
        imem_req  = 1'b0;
        ir_load   = 1'b0;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        alu_src_a = 1'b0;
        alu_src_b = 1'b0;
        rf_we     = 1'b0;
        wb_sel    = WB_ALU;
        pc_write  = 1'b0;
        pc_src    = PC_SRC_PLUS4;
        retired   = 1'b0;
        if (!reset) begin
            case (state_q)
                ST_FETCH: begin
                    imem_req = 1'b1;
                    ir_load  = imem_ready;
                end
                ST_EXEC: begin
                    alu_src_a = dec.alu_src_a;
                    alu_src_b = dec.alu_src_b;
                    if (dec.is_branch) begin
                        pc_write = 1'b1;
                        retired  = 1'b1;
                        pc_src   = branch_taken ? PC_SRC_BRANCH : PC_SRC_PLUS4;
                    end
                end
                ST_MEM: begin
                    dmem_req = 1'b1;
                    dmem_we  = dec.is_store;
                    if (dmem_ready && dec.is_store) begin
                        pc_write = 1'b1;
                        retired  = 1'b1;
                    end
                end
                ST_WB: begin
                    rf_we    = 1'b1;
                    pc_write = 1'b1;
                    retired  = 1'b1;
                    wb_sel   = dec.wb_sel;
                    pc_src   = dec.pc_src;
                end
                default: begin
                end
            endcase
        end
    end

    assign state      = state_q;
    assign halted     = !reset && (state_q == ST_HALT);
    assign trap_cause = reset ? TRAP_NONE : trap_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Self-checking bench for multicycle_sequencer: directed scenarios plus a random
// instruction stream compared against a latency/decode model of the RV32I rules.
module tb_multicycle_sequencer;
    import multicycle_sequencer_pkg::*;

    localparam logic [6:0] L_LOAD   = 7'b0000011;
    localparam logic [6:0] L_STORE  = 7'b0100011;
    localparam logic [6:0] L_OP     = 7'b0110011;
    localparam logic [6:0] L_OP_IMM = 7'b0010011;
    localparam logic [6:0] L_BRANCH = 7'b1100011;
    localparam logic [6:0] L_JAL    = 7'b1101111;
    localparam logic [6:0] L_JALR   = 7'b1100111;
    localparam logic [6:0] L_LUI    = 7'b0110111;
    localparam logic [6:0] L_AUIPC  = 7'b0010111;
    localparam logic [6:0] L_SYSTEM = 7'b1110011;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] opcode = '0;
    logic       imem_ready = 1'b0;
    logic       dmem_ready = 1'b0;
    logic       branch_taken = 1'b0;
    logic       imem_req, ir_load, dmem_req, dmem_we, alu_src_a, alu_src_b;
    logic       rf_we, pc_write, retired, halted;
    logic [1:0] wb_sel, pc_src, trap_cause;
    logic [2:0] state;

    multicycle_sequencer #(.MEM_TIMEOUT(16)) dut (
        .clk(clk), .reset(reset), .opcode(opcode),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready), .branch_taken(branch_taken),
        .imem_req(imem_req), .ir_load(ir_load), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .rf_we(rf_we), .wb_sel(wb_sel),
        .pc_write(pc_write), .pc_src(pc_src), .retired(retired), .state(state),
        .halted(halted), .trap_cause(trap_cause)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;
    logic [2:0] trace [0:63];
    logic [6:0] pool [9] = '{L_LOAD, L_STORE, L_OP, L_OP_IMM, L_BRANCH,
                             L_JAL, L_JALR, L_LUI, L_AUIPC};

    wire any_strobe = imem_req | ir_load | dmem_req | dmem_we | alu_src_a | alu_src_b |
                      rf_we | pc_write | retired | (|wb_sel) | (|pc_src);

    // Window statistics filled by drive_window.
    int w_imem, w_dmem, w_ret, w_rf, w_il, w_halt, w_late_strobe;
    logic [1:0] w_cause;

    // Reference model: the instruction-level rules, expressed as tables.
    function automatic bit is_legal(input logic [6:0] op);
        return op inside {L_LOAD, L_STORE, L_OP, L_OP_IMM, L_BRANCH,
                          L_JAL, L_JALR, L_LUI, L_AUIPC, L_SYSTEM};
    endfunction

    function automatic int model_latency(input logic [6:0] op, input int fw, input int mw);
        case (op)
            L_BRANCH: return 3 + fw;
            L_STORE:  return 4 + fw + mw;
            L_LOAD:   return 5 + fw + mw;
            default:  return 4 + fw;
        endcase
    endfunction

    function automatic logic [1:0] model_wb(input logic [6:0] op);
        case (op)
            L_LOAD:         return 2'd1;
            L_JAL, L_JALR:  return 2'd2;
            L_LUI:          return 2'd3;
            default:        return 2'd0;
        endcase
    endfunction

    function automatic logic [1:0] model_pc(input logic [6:0] op, input logic taken);
        case (op)
            L_BRANCH: return taken ? 2'd1 : 2'd0;
            L_JAL:    return 2'd2;
            L_JALR:   return 2'd3;
            default:  return 2'd0;
        endcase
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // Runs one legal instruction from FETCH entry; fw/mw are wait cycles before ready.
    task automatic run_instr(input logic [6:0] op, input int fw, input int mw,
                             input logic taken, input string tag);
        int icnt, dcnt, dw, il, na, nb, nrf, rf_cyc, npw, pw_cyc, nret, ret_cyc;
        int exp_lat, exp_d, exp_dw, exp_a, exp_b, exp_rf;
        logic [1:0] wbs, psrc;
        bit mem_op;
        icnt = 0; dcnt = 0; dw = 0; il = 0; na = 0; nb = 0; nrf = 0; npw = 0; nret = 0;
        rf_cyc = -1; pw_cyc = -1; ret_cyc = -1; wbs = '0; psrc = '0;
        mem_op = (op == L_LOAD) || (op == L_STORE);
        exp_lat = model_latency(op, fw, mw);
        exp_d   = mem_op ? mw + 1 : 0;
        exp_dw  = (op == L_STORE) ? mw + 1 : 0;
        exp_a   = (op inside {L_AUIPC, L_JAL, L_BRANCH}) ? 1 : 0;
        exp_b   = (op inside {L_OP, L_BRANCH}) ? 0 : 1;
        exp_rf  = (op inside {L_BRANCH, L_STORE}) ? 0 : 1;
        for (int cyc = 1; cyc <= 60 && nret == 0; cyc++) begin
            @(negedge clk);
            opcode = op;
            branch_taken = taken;
            imem_ready = imem_req ? (icnt == fw) : ($urandom_range(0, 1) == 1);
            dmem_ready = dmem_req ? (dcnt == mw) : ($urandom_range(0, 1) == 1);
            #1;
            trace[cyc] = state;
            if (imem_req)  icnt++;
            if (dmem_req)  dcnt++;
            if (dmem_we)   dw++;
            if (ir_load)   il++;
            if (alu_src_a) na++;
            if (alu_src_b) nb++;
            if (rf_we)    begin nrf++; rf_cyc = cyc; wbs = wb_sel; end
            if (pc_write) begin npw++; pw_cyc = cyc; end
            if (retired)  begin nret++; ret_cyc = cyc; psrc = pc_src; end
        end
        n_total++; if (trace[1] !== ST_FETCH) $display("FAIL %s first_state: got %0d want %0d", tag, trace[1], ST_FETCH); else n_pass++;
        n_total++; if (ret_cyc !== exp_lat) $display("FAIL %s latency: got %0d want %0d", tag, ret_cyc, exp_lat); else n_pass++;
        n_total++; if (nret !== 1) $display("FAIL %s retired_count: got %0d want 1", tag, nret); else n_pass++;
        n_total++; if (npw !== 1 || pw_cyc !== ret_cyc) $display("FAIL %s pc_write: got %0d pulses at %0d want 1 at %0d", tag, npw, pw_cyc, ret_cyc); else n_pass++;
        n_total++; if (nrf !== exp_rf) $display("FAIL %s rf_we_count: got %0d want %0d", tag, nrf, exp_rf); else n_pass++;
        if (exp_rf == 1) begin
            n_total++; if (rf_cyc !== ret_cyc) $display("FAIL %s rf_we_cycle: got %0d want %0d", tag, rf_cyc, ret_cyc); else n_pass++;
            n_total++; if (wbs !== model_wb(op)) $display("FAIL %s wb_sel: got %0d want %0d", tag, wbs, model_wb(op)); else n_pass++;
        end
        n_total++; if (psrc !== model_pc(op, taken)) $display("FAIL %s pc_src: got %0d want %0d", tag, psrc, model_pc(op, taken)); else n_pass++;
        n_total++; if (icnt !== fw + 1) $display("FAIL %s imem_req_cycles: got %0d want %0d", tag, icnt, fw + 1); else n_pass++;
        n_total++; if (il !== 1) $display("FAIL %s ir_load_count: got %0d want 1", tag, il); else n_pass++;
        n_total++; if (dcnt !== exp_d) $display("FAIL %s dmem_req_cycles: got %0d want %0d", tag, dcnt, exp_d); else n_pass++;
        n_total++; if (dw !== exp_dw) $display("FAIL %s dmem_we_cycles: got %0d want %0d", tag, dw, exp_dw); else n_pass++;
        n_total++; if (na !== exp_a || nb !== exp_b) $display("FAIL %s alu_src: got a=%0d b=%0d want a=%0d b=%0d", tag, na, nb, exp_a, exp_b); else n_pass++;
    endtask

    // Free-running window with fixed ready behaviour; fills the w_* statistics.
    task automatic drive_window(input logic [6:0] op, input int ncyc,
                                input bit imem_ok, input bit dmem_ok);
        w_imem = 0; w_dmem = 0; w_ret = 0; w_rf = 0; w_il = 0; w_halt = 0; w_late_strobe = 0;
        w_cause = '0;
        for (int cyc = 1; cyc <= ncyc; cyc++) begin
            @(negedge clk);
            opcode = op;
            branch_taken = $urandom_range(0, 1) == 1;
            imem_ready = imem_req ? imem_ok : ($urandom_range(0, 1) == 1);
            dmem_ready = dmem_req ? dmem_ok : ($urandom_range(0, 1) == 1);
            #1;
            trace[cyc] = state;
            w_imem += int'(imem_req);
            w_dmem += int'(dmem_req);
            w_ret  += int'(retired);
            w_rf   += int'(rf_we);
            w_il   += int'(ir_load);
            w_halt += int'(halted);
            if (cyc >= 3 && any_strobe) w_late_strobe++;
            w_cause = trap_cause;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        imem_ready = 1'b1;
        dmem_ready = 1'b1;
        #1;
        n_total++; if (any_strobe !== 1'b0) $display("FAIL reset_strobes: got %0b want 0", any_strobe); else n_pass++;
        n_total++; if (halted !== 1'b0 || trap_cause !== 2'd0) $display("FAIL reset_status: got halted=%0b cause=%0d want 0/0", halted, trap_cause); else n_pass++;
        @(posedge clk);
        #1 reset = 1'b0;
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        #0;
        n_total++; if (state !== ST_FETCH || imem_req !== 1'b1) $display("FAIL reset_exit: got state=%0d imem_req=%0b want %0d/1", state, imem_req, ST_FETCH); else n_pass++;
    endtask

    task automatic test_op_imm();
        run_instr(L_OP_IMM, 0, 0, 1'b0, "op_imm");
        n_total++;
        if (trace[1] !== ST_FETCH || trace[2] !== ST_DECODE || trace[3] !== ST_EXEC || trace[4] !== ST_WB)
            $display("FAIL op_imm_states: got %0d,%0d,%0d,%0d want %0d,%0d,%0d,%0d",
                     trace[1], trace[2], trace[3], trace[4], ST_FETCH, ST_DECODE, ST_EXEC, ST_WB);
        else n_pass++;
    endtask

    task automatic test_load_wait();
        run_instr(L_LOAD, 0, 3, 1'b0, "load_wait3");
        run_instr(L_LOAD, 15, 15, 1'b0, "load_wait_edge");
    endtask

    task automatic test_branch();
        run_instr(L_BRANCH, 0, 0, 1'b1, "branch_taken");
        run_instr(L_BRANCH, 0, 0, 1'b0, "branch_not_taken");
        run_instr(L_STORE, 0, 0, 1'b0, "store");
    endtask

    task automatic test_illegal();
        logic [6:0] op;
        for (int k = 0; k < 4; k++) begin
            if (k == 0) op = 7'b0000000;
            else do op = 7'($urandom_range(0, 127)); while (is_legal(op));
            do_reset();
            drive_window(op, 10, 1'b1, 1'b1);
            n_total++; if (trace[2] !== ST_DECODE || trace[3] !== ST_TRAP) $display("FAIL illegal_%0h_state: got %0d,%0d want %0d,%0d", op, trace[2], trace[3], ST_DECODE, ST_TRAP); else n_pass++;
            n_total++; if (w_cause !== 2'd1) $display("FAIL illegal_%0h_cause: got %0d want 1", op, w_cause); else n_pass++;
            n_total++; if (w_ret !== 0 || w_late_strobe !== 0 || w_halt !== 0) $display("FAIL illegal_%0h_quiet: got ret=%0d strobes=%0d halted=%0d want 0", op, w_ret, w_late_strobe, w_halt); else n_pass++;
        end
    endtask

    task automatic test_halt();
        do_reset();
        drive_window(L_SYSTEM, 22, 1'b1, 1'b1);
        n_total++; if (w_halt !== 20) $display("FAIL halt_cycles: got %0d want 20", w_halt); else n_pass++;
        n_total++; if (trace[22] !== ST_HALT) $display("FAIL halt_state: got %0d want %0d", trace[22], ST_HALT); else n_pass++;
        n_total++; if (w_ret !== 0 || w_late_strobe !== 0 || w_cause !== 2'd0) $display("FAIL halt_quiet: got ret=%0d strobes=%0d cause=%0d want 0", w_ret, w_late_strobe, w_cause); else n_pass++;
    endtask

    task automatic test_fetch_timeout();
        do_reset();
        drive_window(L_OP, 24, 1'b0, 1'b1);
        n_total++; if (w_imem !== 16) $display("FAIL fetch_timeout_req: got %0d want 16", w_imem); else n_pass++;
        n_total++; if (trace[17] !== ST_TRAP || w_cause !== 2'd2) $display("FAIL fetch_timeout_trap: got state=%0d cause=%0d want %0d/2", trace[17], w_cause, ST_TRAP); else n_pass++;
        n_total++; if (w_il !== 0 || w_ret !== 0) $display("FAIL fetch_timeout_quiet: got ir_load=%0d ret=%0d want 0", w_il, w_ret); else n_pass++;
    endtask

    task automatic test_mem_timeout();
        do_reset();
        drive_window(L_LOAD, 24, 1'b1, 1'b0);
        n_total++; if (w_dmem !== 16) $display("FAIL mem_timeout_req: got %0d want 16", w_dmem); else n_pass++;
        n_total++; if (trace[20] !== ST_TRAP || w_cause !== 2'd2) $display("FAIL mem_timeout_trap: got state=%0d cause=%0d want %0d/2", trace[20], w_cause, ST_TRAP); else n_pass++;
        n_total++; if (w_ret !== 0 || w_rf !== 0) $display("FAIL mem_timeout_quiet: got ret=%0d rf_we=%0d want 0", w_ret, w_rf); else n_pass++;
    endtask

    task automatic test_reset_mid_mem();
        do_reset();
        drive_window(L_STORE, 6, 1'b1, 1'b0);
        n_total++; if (trace[6] !== ST_MEM) $display("FAIL mid_mem_setup: got %0d want %0d", trace[6], ST_MEM); else n_pass++;
        @(negedge clk);
        reset = 1'b1;
        imem_ready = 1'b1;
        dmem_ready = 1'b1;
        #1;
        n_total++; if (retired !== 1'b0 || pc_write !== 1'b0 || rf_we !== 1'b0 || dmem_req !== 1'b0) $display("FAIL mid_mem_reset_cycle: got ret=%0b pcw=%0b rf=%0b dreq=%0b want 0", retired, pc_write, rf_we, dmem_req); else n_pass++;
        @(posedge clk);
        #1 reset = 1'b0;
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        #0;
        n_total++; if (state !== ST_FETCH || dmem_req !== 1'b0 || imem_req !== 1'b1) $display("FAIL mid_mem_after: got state=%0d dreq=%0b ireq=%0b want %0d/0/1", state, dmem_req, imem_req, ST_FETCH); else n_pass++;
        run_instr(L_OP_IMM, 1, 0, 1'b0, "resume");
    endtask

    task automatic test_back_to_back();
        logic [6:0] op;
        string tag;
        do_reset();
        for (int k = 0; k < 40; k++) begin
            op = pool[$urandom_range(0, 8)];
            tag = $sformatf("rand%0d_op%0h", k, op);
            run_instr(op, $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 1) == 1, tag);
        end
    endtask

    initial begin
        test_reset();
        test_op_imm();
        test_load_wait();
        test_branch();
        test_illegal();
        test_halt();
        test_fetch_timeout();
        test_mem_timeout();
        test_reset_mid_mem();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
